// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_seq_pkg;

    localparam int MUL_W    = 32;
    localparam int MUL_ITER = 32;
    localparam int CNT_W    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_seq32_rca32.sv
// Plain 32-bit ripple-carry adder: one full-adder cell per bit, carry-in tied low.
module mul_seq32_rca32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         c_out
);

    logic [W:0] cy;

    // Carry ripples LSB to MSB through the full-adder cells.
    always_comb begin
        cy    = '0;
        res   = '0;
        for (int i = 0; i < W; i++) begin
            res[i]  = a[i] ^ b[i] ^ cy[i];
            cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
        end
        c_out = cy[W];
    end

endmodule

// File: rtl/mul_seq32.sv
// Sequential 32x32->64 unsigned multiplier. One shared ripple adder is stepped
// over 32 iterations; P holds the running high half and the shifting multiplier.
module mul_seq32
    import mul_seq_pkg::*;
#(
    parameter bit ZERO_BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [MUL_W-1:0]     a,
    input  logic [MUL_W-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*MUL_W-1:0]   result,
    output logic                 busy
);

    state_t                state_q, state_nxt;
    logic [MUL_W-1:0]      m_q;
    logic [2*MUL_W-1:0]    p_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [MUL_W-1:0]      addend;
    logic [MUL_W-1:0]      sum;
    logic                  carry;
    logic                  accept;
    logic                  zero_op;
    logic                  last_iter;

    // Adder runs every RUN cycle; a clear LSB simply adds zero.
    assign addend    = p_q[0] ? m_q : '0;
    assign accept    = in_valid && (state_q == IDLE);
    assign zero_op   = ZERO_BYPASS && ((a == '0) || (b == '0));
    assign last_iter = (cnt_q == CNT_W'(MUL_ITER - 1));

    mul_seq32_rca32 #(.W(MUL_W)) u_rca (
        .a     (p_q[2*MUL_W-1:MUL_W]),
        .b     (addend),
        .res   (sum),
        .c_out (carry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if (accept)    state_nxt = zero_op ? DONE : RUN;
            RUN:  if (last_iter) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, shift-add one multiplier bit per RUN cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            p_q   <= '0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    m_q   <= a;
                    cnt_q <= '0;
                    p_q   <= zero_op ? '0 : {{MUL_W{1'b0}}, b};
                end
                RUN: begin
                    p_q   <= {carry, sum, p_q[MUL_W-1:1]};
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode from state only, so no input-to-output paths.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        result    = p_q;
    end

endmodule

// File: tb/tb_mul_seq32.sv
// Directed bench for mul_seq32 with an expected-result queue.
module tb_mul_seq32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iv0 = 1'b0, iv1 = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        ir0, ir1, ov0, ov1, busy0, busy1;
    logic [63:0] res0, res1;

    logic        ir_s, ov_s, busy_s;
    logic [63:0] res_s;

    int          sel = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mul_seq32 #(.ZERO_BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
        .out_valid(ov0), .out_ready(out_ready), .result(res0), .busy(busy0)
    );

    mul_seq32 #(.ZERO_BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
        .out_valid(ov1), .out_ready(out_ready), .result(res1), .busy(busy1)
    );

    assign ir_s   = (sel != 0) ? ir1   : ir0;
    assign ov_s   = (sel != 0) ? ov1   : ov0;
    assign busy_s = (sel != 0) ? busy1 : busy0;
    assign res_s  = (sel != 0) ? res1  : res0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_iv(input logic v);
        if (sel != 0) iv1 = v;
        else          iv0 = v;
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xx, yy;
        xx = {32'h0, x};
        yy = {32'h0, y};
        return xx * yy;
    endfunction

    function automatic logic [63:0] pop_exp();
        if (exp_q.size() == 0) return 64'hx;
        return exp_q.pop_front();
    endfunction

    // Present operands mid-cycle; the next rising edge is the acceptance edge T0.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input string tag);
        chk({tag, "_in_ready_pre"}, 64'(ir_s), 64'd1);
        a = av;
        b = bv;
        set_iv(1'b1);
        @(posedge clk);
        exp_q.push_back(model(av, bv));
        #1;
        set_iv(1'b0);
        chk({tag, "_busy"}, 64'(busy_s), 64'd1);
    endtask

    // Latency in cycles: 1 means out_valid in the cycle right after T0.
    task automatic wait_done(input bit noise, output int lat);
        lat = 1;
        while (!ov_s && lat < 100) begin
            if (noise) begin
                set_iv(1'($urandom_range(0, 1)));
                a = $urandom;
                b = $urandom;
            end
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input int s, input logic [31:0] av, input logic [31:0] bv,
                          input int exp_lat, input int hold, input bit noise, input string tag);
        int          lat;
        logic [63:0] r0;
        sel       = s;
        out_ready = (hold == 0);
        issue(av, bv, tag);
        wait_done(noise, lat);
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        if (hold > 0) begin
            r0 = res_s;
            for (int k = 0; k < hold; k++) begin
                if (noise) begin
                    set_iv(1'b1);
                    a = $urandom;
                end
                @(posedge clk);
                #1;
                chk({tag, "_hold_valid"}, 64'(ov_s), 64'd1);
                chk({tag, "_hold_stable"}, res_s, r0);
                chk({tag, "_hold_in_ready"}, 64'(ir_s), 64'd0);
            end
            out_ready = 1'b1;
        end
        set_iv(1'b0);
        chk({tag, "_out_valid"}, 64'(ov_s), 64'd1);
        chk({tag, "_result"}, res_s, pop_exp());
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_idle_after"}, 64'(ir_s), 64'd1);
        chk({tag, "_no_extra"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int e_acc[2];
        int n_acc, n_res, edge_i;
        logic will_acc;

        // Reset state
        #1;
        chk("rst_in_ready", 64'(ir0), 64'd1);
        chk("rst_out_valid", 64'(ov0), 64'd0);
        chk("rst_result", res0, 64'h0);
        chk("rst_busy", 64'(busy0), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 32'd3, 32'd5, 33, 0, 1'b0, "basic");
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0, 1'b0, "all_ones");
        run_op(0, 32'h8000_0000, 32'd2, 33, 0, 1'b0, "msb_carry");
        run_op(0, 32'd0, 32'd7, 1, 0, 1'b0, "bypass_a0");
        run_op(0, 32'd9, 32'd0, 1, 0, 1'b0, "bypass_b0");
        run_op(1, 32'd0, 32'd7, 33, 0, 1'b0, "nobypass_a0");
        run_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 33, 10, 1'b1, "backpressure");

        // Asynchronous reset in the middle of iteration 16
        sel = 0;
        out_ready = 1'b1;
        issue(32'hDEAD_BEEF, 32'hCAFE_F00D, "rst_mid");
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_in_ready", 64'(ir0), 64'd1);
        chk("midrst_out_valid", 64'(ov0), 64'd0);
        chk("midrst_result", res0, 64'h0);
        chk("midrst_busy", 64'(busy0), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 32'd10, 32'd10, 33, 0, 1'b0, "after_rst");

        // Back-to-back with in_valid held and out_ready tied high
        sel = 0;
        out_ready = 1'b1;
        a = 32'd7;
        b = 32'd9;
        iv0 = 1'b1;
        n_acc = 0;
        n_res = 0;
        edge_i = 0;
        while (n_res < 2 && edge_i < 120) begin
            @(negedge clk);
            if (ov0) begin
                chk("b2b_result", res0, pop_exp());
                n_res++;
            end
            will_acc = ir0 && iv0;
            @(posedge clk);
            edge_i++;
            if (will_acc) begin
                exp_q.push_back(model(a, b));
                e_acc[n_acc] = edge_i;
                n_acc++;
                #1;
                if (n_acc == 1) begin
                    a = 32'hFEDC_BA98;
                    b = 32'h0000_1001;
                end else begin
                    iv0 = 1'b0;
                end
            end
        end
        iv0 = 1'b0;
        chk("b2b_results_seen", 64'(n_res), 64'd2);
        chk("b2b_accepts", 64'(n_acc), 64'd2);
        if (n_acc == 2)
            chk("b2b_issue_gap", 64'(e_acc[1] - e_acc[0]), 64'd34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
